// File: rtl/mmio_led_pwm_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_led_pwm_if
// Brief    : Memory-mapped peripheral bus (cs/we/addr/wdata/rdata) bundle
//            shared by the LED PWM driver and its bus master.
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_led_pwm_if;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, output we, output addr, output wdata, input rdata);
    modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/mmio_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : mmio_led_pwm
// Brief    : Memory-mapped multi-channel LED driver. Each channel is a static
//            level, a PWM brightness or a blinking PWM output. Duty values
//            are double-buffered and only take effect at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_led_pwm #(
    parameter int N_CH    = 8,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    mmio_led_pwm_if.slave   bus,
    output logic [N_CH-1:0] led_out
);

    localparam logic [5:0]       c_off_mode   = 6'd0;
    localparam logic [5:0]       c_off_static = 6'd1;
    localparam logic [5:0]       c_off_presc  = 6'd2;
    localparam logic [5:0]       c_off_blink  = 6'd3;
    localparam logic [5:0]       c_off_status = 6'd4;
    localparam logic [CNT_W-1:0] c_pwm_max    = {CNT_W{1'b1}};

    logic [2*N_CH-1:0]  mode_q,        mode_d;
    logic [N_CH-1:0]    static_q,      static_d;
    logic [PRESC_W-1:0] presc_q,       presc_d;
    logic [7:0]         blink_q,       blink_d;
    logic [PRESC_W-1:0] presc_cnt_q,   presc_cnt_d;
    logic [CNT_W-1:0]   pwm_cnt_q,     pwm_cnt_d;
    logic [7:0]         blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [CNT_W-1:0]   duty_q   [N_CH];
    logic [CNT_W-1:0]   duty_d   [N_CH];
    logic [CNT_W-1:0]   active_q [N_CH];
    logic [CNT_W-1:0]   active_d [N_CH];
    logic [N_CH-1:0]    led_q,         led_d;

    logic        w_wr;
    logic [5:0]  w_off;
    logic        w_duty_sel;
    logic        w_tick;
    logic        w_frame_start;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr          = bus.cs & bus.we;
    assign w_off         = bus.addr[7:2];
    // DUTY window is 0x40..0x7C: word offsets 16..31
    assign w_duty_sel    = (w_off[5:4] == 2'b01);
    assign w_tick        = (presc_cnt_q == presc_q);
    assign w_frame_start = w_tick & (pwm_cnt_q == c_pwm_max);
    assign bus.rdata     = w_rdata;
    assign led_out       = led_q;
    assign w_unused      = &{1'b0, bus.addr[31:8], bus.addr[1:0], bus.wdata};

    // Next-state for counters, the blink phase, shadow and active duty, and registers
    always_comb begin
        mode_d        = mode_q;
        static_d      = static_q;
        presc_d       = presc_q;
        blink_d       = blink_q;
        duty_d        = duty_q;
        active_d      = active_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        presc_cnt_d   = w_tick ? '0 : presc_cnt_q + 1'b1;
        pwm_cnt_d     = w_tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

        // Frame boundary: latch the shadow duties that existed before this edge
        if (w_frame_start) begin
            active_d = duty_q;
            if (blink_cnt_q == blink_q) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end

        if (w_wr) begin
            case (w_off)
                c_off_mode:   mode_d   = bus.wdata[2*N_CH-1:0];
                c_off_static: static_d = bus.wdata[N_CH-1:0];
                c_off_blink:  blink_d  = bus.wdata[7:0];
                c_off_presc: begin
                    // A PRESC write overrides a coincident tick restart
                    presc_d     = bus.wdata[PRESC_W-1:0];
                    presc_cnt_d = '0;
                end
                default: ;
            endcase
            for (int i = 0; i < N_CH; i++) begin
                if (w_duty_sel && (w_off[3:0] == 4'(i))) begin
                    duty_d[i] = bus.wdata[CNT_W-1:0];
                end
            end
        end
    end

    // Per-channel output selection from the current mode and counter state
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode_q[2*i +: 2])
                2'b00:   led_d[i] = static_q[i];
                2'b01:   led_d[i] = (pwm_cnt_q < active_q[i]);
                2'b10:   led_d[i] = (pwm_cnt_q < active_q[i]) & blink_phase_q;
                default: led_d[i] = 1'b0;
            endcase
        end
    end

    // Combinational read mux; unselected or unmapped offsets return zero
    always_comb begin
        w_rdata = '0;
        if (bus.cs) begin
            case (w_off)
                c_off_mode:   w_rdata[2*N_CH-1:0]  = mode_q;
                c_off_static: w_rdata[N_CH-1:0]    = static_q;
                c_off_presc:  w_rdata[PRESC_W-1:0] = presc_q;
                c_off_blink:  w_rdata[7:0]         = blink_q;
                c_off_status: begin
                    w_rdata[CNT_W-1:0] = pwm_cnt_q;
                    w_rdata[16]        = blink_phase_q;
                end
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_duty_sel && (w_off[3:0] == 4'(i))) begin
                            w_rdata[CNT_W-1:0] = duty_q[i];
                        end
                    end
                end
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q        <= '0;
            static_q      <= '0;
            presc_q       <= '0;
            blink_q       <= '0;
            presc_cnt_q   <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_q         <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i]   <= '0;
                active_q[i] <= '0;
            end
        end else begin
            mode_q        <= mode_d;
            static_q      <= static_d;
            presc_q       <= presc_d;
            blink_q       <= blink_d;
            presc_cnt_q   <= presc_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
            duty_q        <= duty_d;
            active_q      <= active_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
- Memory-mapped multi-channel LED driver; parametrised successor to the single 8-bit LED register on the processor data bus.
- Each channel runs in one of three modes: static level, PWM brightness, or blinking PWM.
- Sits behind the top-level chip-select decode. It uses the same cs/we/addr/wdata/rdata bus as the other memory-mapped peripherals, and `led_out` drives board LEDs.

Parameters:
N_CH, 8, number of LED channels (1..16)
CNT_W, 8, PWM counter/duty width in bits (2..16)
PRESC_W, 16, prescaler width in bits (1..32)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cs  in  1  chip select from top-level address decode
we  in  1  write strobe (already qualified with cs by top level; block still requires cs & we)
addr  in  32  byte address; only addr[7:2] decoded
wdata  in  32  write data
rdata  out  32  combinational read data; 0 when cs low
led_out  out  N_CH  registered LED drive

Behaviour:
- One clock (`clk`); reset is asynchronous and active-high (`reset`).
- Reset clears every register, counter and blink_phase, and forces `led_out` to 0. `rdata` is then 0 at every offset.
- Register map (byte offset; bits above field width read 0 and are ignored on write):
  - 0x00 MODE (RW): 2 bits per channel, channel i at bits [2i+1:2i]. 00 static, 01 PWM, 10 blink, 11 reserved (output 0).
  - 0x04 STATIC (RW): [N_CH-1:0] static levels.
  - 0x08 PRESC (RW): [PRESC_W-1:0] prescaler limit. A write also clears presc_cnt.
  - 0x0C BLINK (RW): [7:0] blink limit, in frames.
  - 0x10 STATUS (RO): [CNT_W-1:0] pwm_cnt; bit16 blink_phase.
  - 0x40+4i DUTY[i] (RW): [CNT_W-1:0] shadow duty; reads return shadow. Writes for i >= N_CH are ignored; reads return 0.
  - Any other offset reads 0; writes to it are ignored.
- Writes take effect on the clk edge where cs & we = 1.
- Prescaler:
  - presc_cnt counts 0..PRESC; tick = (presc_cnt == PRESC); presc_cnt returns to 0 on tick.
  - PRESC = 0 gives a tick every cycle.
  - A PRESC write on the same edge as a tick: the write wins, presc_cnt := 0.
- PWM counter:
  - pwm_cnt increments on tick and wraps from 2^CNT_W-1 to 0.
  - frame_start = tick & (pwm_cnt == 2^CNT_W-1).
  - On frame_start every active_duty[i] := DUTY[i].
  - Mid-frame duty writes are therefore glitch-free and only apply from the next frame.
  - A DUTY write on the frame_start edge: the old shadow value is loaded; the new value applies the frame after.
- Blink:
  - On frame_start, blink_cnt increments. When blink_cnt == BLINK it clears to 0 and blink_phase toggles.
  - Phase period is BLINK+1 frames; BLINK = 0 toggles every frame.
- Per-channel next output:
  - pwm_i = (pwm_cnt < active_duty[i]).
  - Mode 00 → STATIC[i]; 01 → pwm_i; 10 → pwm_i & blink_phase; 11 → 0.
  - Duty 0 gives constant low; full scale gives high 2^CNT_W-1 of 2^CNT_W counts.
- `led_out` is registered from the next-output value, so there is 1 cycle of latency from counter/register state.
  - Example: a STATIC write at edge k appears on `led_out` after edge k+1.
- Counters free-run regardless of mode.
- Reset asserted mid-frame immediately zeroes `led_out` and all state. After release, the first frame starts with pwm_cnt = 0.

Test Plan:
Bench configuration for all scenarios: N_CH=8, CNT_W=4, PRESC_W=8.
1. Reset → assert reset mid-run (PWM active, MODE=0x5555). Required: `led_out` = 0x00 asynchronously; all offsets read 0; after release STATUS reads 0.
2. Static → write STATIC=0xA5, MODE=0. Required: `led_out` = 0xA5 one cycle after the write edge; read 0x04 returns 0x000000A5.
3. PWM → PRESC=0, MODE=0x0001, DUTY0=4. Required: from the first frame after the next frame_start, `led_out`[0] is high exactly 4 of every 16 cycles, aligned to pwm_cnt 0..3; `led_out`[7:1] = 0.
4. Mid-frame duty change → in scenario 3, write DUTY0=12 while STATUS pwm_cnt = 7. Required: current frame keeps 4 high cycles; next frame has 12; DUTY0 reads 12 immediately.
5. Blink → PRESC=1, BLINK=2, MODE=0x0008, DUTY1=15. Required: frame = 32 cycles; `led_out`[1] shows 30 high of 32 cycles for 3 frames (96 cycles), then 0 for 96 cycles, repeating; STATUS bit16 toggles every 96 cycles.
6. Edge cases:
   - DUTY0=0 in PWM mode → `led_out`[0] constant 0.
   - MODE ch2=11 → 0.
   - Write to offset 0x60 (DUTY[8]) → ignored, reads 0.
   - PRESC write coinciding with tick → presc_cnt = 0 on the next cycle.
